rtlramstapl_arb: RTL
====================

# rtlramstapl_arb

Parametrised successor of the engine/CPU RAM access macro. It arbitrates one engine read port, one engine write port and a single-beat CPU port onto a simple dual-port RAM or register file whose read latency is configurable. Read-after-write hazards are forwarded over the full read pipeline. A starved CPU access is aborted after a programmable timeout and flagged with an error. It sits between each engine's state RAM and the CPU register decoder.

## Interface
Parameters:
- ADDRBIT, 5: RAM address width.
- WIDTH, 32: data width.
- RDLAT, 3: RAM read latency in cycles, from memre to memrdd valid; legal range 1..8.
- TOBIT, 8: timeout counter width.
- TOUT, 255: CPU wait limit in cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- active  in  1  qualifies eng_re and eng_we; when low, engine requests are ignored.
- eng_re  in  1  engine read request.
- eng_ra  in  ADDRBIT  engine read address.
- eng_rdd  out  WIDTH  read data (forwarded), combinational, valid RDLAT cycles after issue.
- eng_rvld  out  1  eng_rdd carries an engine read result.
- eng_we  in  1  engine write.
- eng_wa  in  ADDRBIT  engine write address.
- eng_wrd  in  WIDTH  engine write data.
- upen  in  1  CPU chip-select, level; dropping it cancels any pending access.
- upa  in  ADDRBIT  CPU address, held stable while upen is high.
- upws  in  1  CPU write strobe.
- uprs  in  1  CPU read strobe.
- updi  in  WIDTH  CPU write data.
- updo  out  WIDTH  CPU read data, registered.
- uprdy  out  1  one-cycle done pulse.
- uperr  out  1  qualifies uprdy; 1 means the access timed out.
- memwe, memwa, memwrd  out  1/ADDRBIT/WIDTH  RAM write port.
- memre, memra  out  1/ADDRBIT  RAM read port.
- memrdd  in  WIDTH  RAM read data, RDLAT cycles after memre.

## Operation
- CPU request latch: upws&upen sets wr_pend; uprs&upen sets rd_pend. Both clear on grant, on timeout, or when upen=0. If both are set, the write is served first.
- Write grant: cpu_wr_ok = wr_pend & (!engwr | eng_wa==upa).
  - On a same-address collision the CPU data wins and the engine write is dropped.
  - memwe = engwr | cpu_wr_ok.
- Read grant: cpu_rd_ok = rd_pend & (!engrd | eng_ra==upa).
  - On a same-address collision the single RAM read is shared; eng_rvld still marks the engine read.
  - memre = (engrd|cpu_rd_ok) & !(memwe & memwa==memra). A same-cycle write to the same address suppresses the RAM read, and the data is forwarded instead.
- Forwarding:
  - Each issued read carries {valid, addr, fwd_hit, fwd_data} through an RDLAT-deep shift pipeline.
  - At every stage, a write to the stage address overwrites fwd_data and sets fwd_hit. The youngest write wins.
  - At the output, a write in the same cycle as return also counts.
  - eng_rdd = fwd_hit ? fwd_data : memrdd.
- Timeout: a counter increments each cycle while any pending bit is set and no grant occurs. When it reaches TOUT (TOUT≠0), the pending access is aborted: uprdy=1, uperr=1, updo=0, RAM untouched. The counter clears on grant, abort or upen=0.
- Completion:
  - A granted access raises uprdy with uperr=0 at grant+RDLAT+1.
  - On a read, updo is eng_rdd registered. On a write, updo = 0.
  - updo is forced to 0 while upen=0.
- rst=0: all pending bits, counters and pipelines clear. All outputs are 0 in the following cycle. Accesses in flight are lost; no uprdy is produced.

## Timing
- Engine read issued at t: eng_rdd/eng_rvld valid at t+RDLAT, for one cycle.
- CPU grant at g: uprdy pulse at g+RDLAT+1; updo is valid in the same cycle and held until the next uprdy.
- Minimum CPU latency from strobe to uprdy: RDLAT+2. The strobe is latched at s; grant is no earlier than s+1.
- Timeout abort: uprdy at s+TOUT+1, provided no grant occurs in cycles s+1..s+TOUT.
- Engine ports never stall; memwe/memre are combinational from the requests in the same cycle.

## Test plan
- RDLAT=3, write 0xA5A5_0001 to address 4 via the engine, then an engine read of address 4 at t → eng_rdd=0xA5A5_0001 at t+3 via memrdd, eng_rvld=1.
- Engine read of address 7 at t; engine writes of 0x11 to address 7 at t+1 and 0x22 at t+3 → eng_rdd=0x22 at t+3; with no write at t+3 → 0x11.
- CPU write to address 2 (0xDEAD_BEEF) colliding with an engine write to address 2 in the grant cycle → RAM holds 0xDEAD_BEEF; uprdy at g+4, uperr=0, updo=0.
- CPU read of address 9 while the engine reads address 3 every cycle for 20 cycles, TOUT=16 → uprdy=1, uperr=1, updo=0 at s+17; memre never carries upa.
- CPU read granted, upen dropped at g+2 → updo=0 and no further pending; a subsequent uprs with upen=1 completes normally.
- rst=0 asserted at g+1 of a CPU read → no uprdy; every output is 0 the next cycle; pipelines are empty after rst=1.

Source files
------------

// File: rtl/rtlramstapl_arb.sv
// rtlramstapl_arb: arbitrates an engine read port, an engine write port and a
// single-beat CPU port onto a dual-port RAM with RDLAT read latency and RAW forwarding.
module rtlramstapl_arb #(
    parameter int ADDRBIT = 5,
    parameter int WIDTH   = 32,
    parameter int RDLAT   = 3,
    parameter int TOBIT   = 8,
    parameter int TOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               eng_re,
    input  logic [ADDRBIT-1:0] eng_ra,
    output logic [WIDTH-1:0]   eng_rdd,
    output logic               eng_rvld,
    input  logic               eng_we,
    input  logic [ADDRBIT-1:0] eng_wa,
    input  logic [WIDTH-1:0]   eng_wrd,
    input  logic               upen,
    input  logic [ADDRBIT-1:0] upa,
    input  logic               upws,
    input  logic               uprs,
    input  logic [WIDTH-1:0]   updi,
    output logic [WIDTH-1:0]   updo,
    output logic               uprdy,
    output logic               uperr,
    output logic               memwe,
    output logic [ADDRBIT-1:0] memwa,
    output logic [WIDTH-1:0]   memwrd,
    output logic               memre,
    output logic [ADDRBIT-1:0] memra,
    input  logic [WIDTH-1:0]   memrdd
);

    typedef struct packed {
        logic               vld;
        logic               eng;
        logic [ADDRBIT-1:0] addr;
        logic               hit;
        logic [WIDTH-1:0]   data;
    } rd_stage_t;

    localparam logic [TOBIT-1:0] TO_LAST = TOBIT'((TOUT > 0) ? (TOUT - 1) : 0);

    logic             engrd, engwr;
    logic             wr_pend, rd_pend, pend_any;
    logic             cpu_wr_ok, cpu_rd_ok, grant, abort;
    logic             rd_issue, rd_collide;
    logic [WIDTH-1:0] wr_data_q;
    logic [TOBIT-1:0] to_cnt;
    logic [RDLAT-1:0] cpu_v, cpu_rd;
    logic             cpu_done;
    rd_stage_t        entry, out_st;
    rd_stage_t        pipe [RDLAT];
    rd_stage_t        upd  [RDLAT];

    // Request qualification and grants; a pending CPU write always goes before a read.
    always_comb begin
        engrd      = rst & active & eng_re;
        engwr      = rst & active & eng_we;
        pend_any   = wr_pend | rd_pend;
        cpu_wr_ok  = rst & upen & wr_pend & (!engwr | (eng_wa == upa));
        cpu_rd_ok  = rst & upen & rd_pend & !wr_pend & (!engrd | (eng_ra == upa));
        grant      = cpu_wr_ok | cpu_rd_ok;
        abort      = (TOUT != 0) & rst & upen & pend_any & !grant & (to_cnt == TO_LAST);
        cpu_done   = upen & cpu_v[RDLAT-1];
    end

    // RAM port muxing: CPU data wins a same-address write collision.
    always_comb begin
        memwe      = engwr | cpu_wr_ok;
        memwa      = cpu_wr_ok ? upa : (engwr ? eng_wa : '0);
        memwrd     = cpu_wr_ok ? wr_data_q : (engwr ? eng_wrd : '0);
        rd_issue   = engrd | cpu_rd_ok;
        memra      = engrd ? eng_ra : (cpu_rd_ok ? upa : '0);
        rd_collide = memwe & (memwa == memra);
        memre      = rd_issue & !rd_collide;
    end

    // A read colliding with a same-cycle write starts life already forwarded.
    always_comb begin
        entry      = '0;
        entry.vld  = rd_issue;
        entry.eng  = engrd;
        entry.addr = memra;
        entry.hit  = rd_issue & rd_collide;
        entry.data = (rd_issue & rd_collide) ? memwrd : '0;
    end

    always_comb begin
        for (int k = 0; k < RDLAT; k++) begin
            upd[k] = pipe[k];
            if (pipe[k].vld && memwe && (memwa == pipe[k].addr)) begin
                upd[k].hit  = 1'b1;
                upd[k].data = memwrd;
            end
        end
        out_st = upd[RDLAT-1];
    end

    assign eng_rdd  = out_st.vld ? (out_st.hit ? out_st.data : memrdd) : '0;
    assign eng_rvld = out_st.vld & out_st.eng;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < RDLAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= entry;
            for (int k = 1; k < RDLAT; k++) pipe[k] <= upd[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            wr_data_q <= '0;
            to_cnt    <= '0;
        end else begin
            wr_pend <= upen & (upws | (wr_pend & !cpu_wr_ok & !abort));
            rd_pend <= upen & (uprs | (rd_pend & !cpu_rd_ok & !abort));
            if (upen && upws) wr_data_q <= updi;
            to_cnt  <= (upen & pend_any & !grant & !abort) ? to_cnt + TOBIT'(1) : '0;
        end
    end

    // CPU completion tags; dropping upen discards anything still in flight.
    always_ff @(posedge clk) begin
        if (!rst || !upen) begin
            cpu_v  <= '0;
            cpu_rd <= '0;
        end else begin
            cpu_v[0]  <= grant;
            cpu_rd[0] <= cpu_rd_ok;
            for (int k = 1; k < RDLAT; k++) begin
                cpu_v[k]  <= cpu_v[k-1];
                cpu_rd[k] <= cpu_rd[k-1];
            end
        end
    end

    // An abort colliding with an older completion reports the abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            uprdy <= 1'b0;
            uperr <= 1'b0;
            updo  <= '0;
        end else begin
            uprdy <= abort | cpu_done;
            uperr <= abort;
            if (!upen || abort)
                updo <= '0;
            else if (cpu_done)
                updo <= cpu_rd[RDLAT-1] ? eng_rdd : '0;
        end
    end

endmodule
